mem_access_unit: RTL and testbench

Load/store initiator for `combined_memory`: it accepts one memory-stage request at a time and drives the memory's read and write ports with the correct address and addressing mode. It checks alignment, then sign- or zero-extends loaded bytes and halfwords to 32 bits. It sits between the pipeline's MEM stage and the data memory, and holds the pipeline through a ready/done handshake.

---
 rtl/mem_pkg.sv | 25 ++
 rtl/mem_access_unit_if.sv | 45 ++++
 rtl/mem_access_unit_load_extender.sv | 22 ++
 rtl/mem_access_unit.sv | 112 +++++++++++
 tb/tb_mem_access_unit.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// Shared constants for the data-memory path: addressing codes, FSM encoding, default widths.
package mem_pkg;

  localparam int NB_DATA_BUS_DEF = 32;
  localparam int NB_ADDRESS_DEF  = 6;

  localparam logic [1:0] ADDR_BYTE    = 2'b00;
  localparam logic [1:0] ADDR_HALF    = 2'b01;
  localparam logic [1:0] ADDR_ILLEGAL = 2'b10;
  localparam logic [1:0] ADDR_WORD    = 2'b11;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_REQ  = 3'd1,
    RD_WAIT = 3'd2,
    WR      = 3'd3,
    DONE    = 3'd4
  } mau_state_e;

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    return ((size == ADDR_HALF) && addr_lo[0]) ||
           ((size == ADDR_WORD) && (addr_lo != 2'b00));
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Request/response bundle between the MEM stage, the access unit and combined_memory.
interface mem_access_unit_if #(
  parameter int NB_DATA_BUS = 32,
  parameter int NB_ADDRESS  = 6
);

  logic                   i_valid;
  logic                   i_is_load;
  logic                   i_is_store;
  logic [1:0]             i_size;
  logic                   i_unsigned;
  logic [NB_ADDRESS-1:0]  i_addr;
  logic [NB_DATA_BUS-1:0] i_wdata;

  logic                   o_ready;
  logic                   o_done;
  logic [NB_DATA_BUS-1:0] o_rdata;
  logic                   o_misaligned;
  logic                   o_illegal;

  logic [NB_ADDRESS-1:0]  o_mem_r_addr;
  logic                   o_mem_r_en;
  logic [1:0]             o_mem_r_addressing;
  logic [NB_ADDRESS-1:0]  o_mem_w_addr;
  logic [NB_DATA_BUS-1:0] o_mem_w_data;
  logic                   o_mem_w_en;
  logic [1:0]             o_mem_w_addressing;
  logic [NB_DATA_BUS-1:0] i_mem_r_data;

  // The access unit is the slave of the pipeline request and drives the memory ports.
  modport slave (
    input  i_valid, i_is_load, i_is_store, i_size, i_unsigned, i_addr, i_wdata, i_mem_r_data,
    output o_ready, o_done, o_rdata, o_misaligned, o_illegal,
    output o_mem_r_addr, o_mem_r_en, o_mem_r_addressing,
    output o_mem_w_addr, o_mem_w_data, o_mem_w_en, o_mem_w_addressing
  );

  modport master (
    output i_valid, i_is_load, i_is_store, i_size, i_unsigned, i_addr, i_wdata, i_mem_r_data,
    input  o_ready, o_done, o_rdata, o_misaligned, o_illegal,
    input  o_mem_r_addr, o_mem_r_en, o_mem_r_addressing,
    input  o_mem_w_addr, o_mem_w_data, o_mem_w_en, o_mem_w_addressing
  );

endinterface

// File: rtl/mem_access_unit_load_extender.sv
// Combinational sign/zero extension of right-justified load data; shared with forwarding.
module load_extender
  import mem_pkg::*;
#(
  parameter int NB_DATA_BUS = NB_DATA_BUS_DEF
) (
  input  logic [NB_DATA_BUS-1:0] i_raw,
  input  logic [1:0]             i_size,
  input  logic                   i_unsigned,
  output logic [NB_DATA_BUS-1:0] o_data
);

  always_comb begin
    o_data = i_raw;
    case (i_size)
      ADDR_BYTE: o_data = {{(NB_DATA_BUS-8){~i_unsigned & i_raw[7]}}, i_raw[7:0]};
      ADDR_HALF: o_data = {{(NB_DATA_BUS-16){~i_unsigned & i_raw[15]}}, i_raw[15:0]};
      default:   o_data = i_raw;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Single-outstanding load/store initiator for combined_memory with alignment checks and
// load extension; holds the pipeline via o_ready/o_done.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int NB_DATA_BUS = NB_DATA_BUS_DEF,
  parameter int NB_ADDRESS  = NB_ADDRESS_DEF
) (
  input  logic              i_clk,
  input  logic              i_reset,
  mem_access_unit_if.slave  bus
);

  mau_state_e             state_q, state_d;
  logic                   accept;
  logic                   req_ill, req_mis;
  logic                   ill_q, mis_q;
  logic [1:0]             size_q;
  logic                   unsigned_q;
  logic [NB_DATA_BUS-1:0] rdata_q, ext_data;
  logic                   r_en_q, w_en_q;
  logic [NB_ADDRESS-1:0]  r_addr_q, w_addr_q;
  logic [1:0]             r_mode_q, w_mode_q;
  logic [NB_DATA_BUS-1:0] w_data_q;

  assign accept  = (state_q == IDLE) && bus.i_valid;
  assign req_ill = (bus.i_is_load && bus.i_is_store) || (bus.i_size == ADDR_ILLEGAL);
  assign req_mis = is_misaligned(bus.i_size, bus.i_addr[1:0]);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (bus.i_valid) begin
          if (req_ill || req_mis)  state_d = DONE;
          else if (bus.i_is_load)  state_d = RD_REQ;
          else if (bus.i_is_store) state_d = WR;
          else                     state_d = DONE;
        end
      end
      RD_REQ:  state_d = RD_WAIT;
      RD_WAIT: state_d = DONE;
      WR:      state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q  <= IDLE;
      ill_q    <= 1'b0;
      mis_q    <= 1'b0;
      r_en_q   <= 1'b0;
      w_en_q   <= 1'b0;
      rdata_q  <= '0;
      r_addr_q <= '0;
      r_mode_q <= '0;
      w_addr_q <= '0;
      w_data_q <= '0;
      w_mode_q <= '0;
    end else begin
      state_q <= state_d;
      // Strobes are registered so they line up exactly with RD_REQ / WR.
      r_en_q  <= (state_d == RD_REQ);
      w_en_q  <= (state_d == WR);
      if (accept) begin
        ill_q <= req_ill;
        mis_q <= ~req_ill & req_mis;
      end
      if (accept && (state_d == RD_REQ)) begin
        r_addr_q <= bus.i_addr;
        r_mode_q <= bus.i_size;
      end
      if (accept && (state_d == WR)) begin
        w_addr_q <= bus.i_addr;
        w_data_q <= bus.i_wdata;
        w_mode_q <= bus.i_size;
      end
      if (state_q == RD_WAIT) rdata_q <= ext_data;
    end
  end

  // Extension controls only matter for an accepted load, so they need no reset.
  always_ff @(posedge i_clk) begin
    if (accept) begin
      size_q     <= bus.i_size;
      unsigned_q <= bus.i_unsigned;
    end
  end

  load_extender #(.NB_DATA_BUS(NB_DATA_BUS)) u_load_extender (
    .i_raw      (bus.i_mem_r_data),
    .i_size     (size_q),
    .i_unsigned (unsigned_q),
    .o_data     (ext_data)
  );

  assign bus.o_ready            = (state_q == IDLE);
  assign bus.o_done             = (state_q == DONE);
  assign bus.o_misaligned       = (state_q == DONE) && mis_q;
  assign bus.o_illegal          = (state_q == DONE) && ill_q;
  assign bus.o_rdata            = rdata_q;
  assign bus.o_mem_r_en         = r_en_q;
  assign bus.o_mem_r_addr       = r_addr_q;
  assign bus.o_mem_r_addressing = r_mode_q;
  assign bus.o_mem_w_en         = w_en_q;
  assign bus.o_mem_w_addr       = w_addr_q;
  assign bus.o_mem_w_data       = w_data_q;
  assign bus.o_mem_w_addressing = w_mode_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a byte-array memory and an expected-result queue.
module tb_mem_access_unit;

  localparam int DW = 32;
  localparam int AW = 6;

  logic clk = 1'b0;
  logic rst;
  logic mem_init;
  always #5 clk = ~clk;

  mem_access_unit_if #(.NB_DATA_BUS(DW), .NB_ADDRESS(AW)) bus ();

  mem_access_unit #(.NB_DATA_BUS(DW), .NB_ADDRESS(AW)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  // Little-endian byte memory with a registered, right-justified read port.
  logic [7:0]    mem [64];
  logic [DW-1:0] mem_rdata;
  assign bus.i_mem_r_data = mem_rdata;

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 64; i++) mem[i] <= 8'(i);
      mem_rdata <= '0;
    end else begin
      if (bus.o_mem_w_en) begin
        mem[bus.o_mem_w_addr] <= bus.o_mem_w_data[7:0];
        if (bus.o_mem_w_addressing != mem_pkg::ADDR_BYTE)
          mem[bus.o_mem_w_addr + 6'd1] <= bus.o_mem_w_data[15:8];
        if (bus.o_mem_w_addressing == mem_pkg::ADDR_WORD) begin
          mem[bus.o_mem_w_addr + 6'd2] <= bus.o_mem_w_data[23:16];
          mem[bus.o_mem_w_addr + 6'd3] <= bus.o_mem_w_data[31:24];
        end
      end
      if (bus.o_mem_r_en) begin
        case (bus.o_mem_r_addressing)
          mem_pkg::ADDR_BYTE: mem_rdata <= {24'h0, mem[bus.o_mem_r_addr]};
          mem_pkg::ADDR_HALF: mem_rdata <= {16'h0, mem[bus.o_mem_r_addr + 6'd1], mem[bus.o_mem_r_addr]};
          default: mem_rdata <= {mem[bus.o_mem_r_addr + 6'd3], mem[bus.o_mem_r_addr + 6'd2],
                                 mem[bus.o_mem_r_addr + 6'd1], mem[bus.o_mem_r_addr]};
        endcase
      end
    end
  end

  typedef struct {
    string       tag;
    logic [31:0] rdata;
    logic        mis;
    logic        ill;
    logic        rd;
    logic        wr;
    int          lat;
    logic [5:0]  addr;
    logic [1:0]  sz;
    logic [31:0] wdata;
  } exp_t;

  exp_t        sb[$];
  logic [7:0]  ref_mem [64];
  logic [31:0] last_rdata;
  int          checks   = 0;
  int          failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_load(input logic [5:0] a, input logic [1:0] sz, input logic u);
    logic [31:0] w;
    w = {ref_mem[a + 6'd3], ref_mem[a + 6'd2], ref_mem[a + 6'd1], ref_mem[a]};
    case (sz)
      2'b00:   return u ? {24'h0, w[7:0]}  : {{24{w[7]}}, w[7:0]};
      2'b01:   return u ? {16'h0, w[15:0]} : {{16{w[15]}}, w[15:0]};
      default: return w;
    endcase
  endfunction

  task automatic ref_store(input logic [5:0] a, input logic [1:0] sz, input logic [31:0] wd);
    ref_mem[a] = wd[7:0];
    if (sz != 2'b00) ref_mem[a + 6'd1] = wd[15:8];
    if (sz == 2'b11) begin
      ref_mem[a + 6'd2] = wd[23:16];
      ref_mem[a + 6'd3] = wd[31:24];
    end
  endtask

  task automatic push_expected(input string tag, input logic ld, input logic st, input logic [1:0] sz,
                               input logic u, input logic [5:0] a, input logic [31:0] wd);
    exp_t e;
    e.tag   = tag;
    e.ill   = (ld && st) || (sz == 2'b10);
    e.mis   = !e.ill && (((sz == 2'b01) && a[0]) || ((sz == 2'b11) && (a[1:0] != 2'b00)));
    e.rd    = !e.ill && !e.mis && ld;
    e.wr    = !e.ill && !e.mis && st && !ld;
    e.lat   = e.rd ? 3 : (e.wr ? 2 : 1);
    e.addr  = a;
    e.sz    = sz;
    e.wdata = wd;
    if (e.rd) last_rdata = ref_load(a, sz, u);
    if (e.wr) ref_store(a, sz, wd);
    e.rdata = last_rdata;
    sb.push_back(e);
  endtask

  task automatic drive(input logic ld, input logic st, input logic [1:0] sz, input logic u,
                       input logic [5:0] a, input logic [31:0] wd);
    bus.i_is_load  = ld;
    bus.i_is_store = st;
    bus.i_size     = sz;
    bus.i_unsigned = u;
    bus.i_addr     = a;
    bus.i_wdata    = wd;
    bus.i_valid    = 1'b1;
  endtask

  task automatic scramble();
    bus.i_valid    = 1'b0;
    bus.i_is_load  = ~bus.i_is_load;
    bus.i_is_store = ~bus.i_is_store;
    bus.i_size     = ~bus.i_size;
    bus.i_unsigned = ~bus.i_unsigned;
    bus.i_addr     = bus.i_addr ^ 6'h2A;
    bus.i_wdata    = ~bus.i_wdata;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (bus.o_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("wait_ready", bus.o_ready, 1'b1);
  endtask

  // Watches the DUT from cycle 1 after acceptance until o_done, then checks ready returns.
  task automatic collect();
    exp_t e;
    int   rd_n = 0;
    int   wr_n = 0;
    bit   got  = 0;
    e = sb.pop_front();
    for (int c = 1; c <= 10 && !got; c++) begin
      @(negedge clk);
      if (bus.o_mem_r_en) begin
        rd_n++;
        check({e.tag, "_rd_cycle"}, c, 1);
        check({e.tag, "_rd_addr"}, bus.o_mem_r_addr, e.addr);
        check({e.tag, "_rd_mode"}, bus.o_mem_r_addressing, e.sz);
      end
      if (bus.o_mem_w_en) begin
        wr_n++;
        check({e.tag, "_wr_cycle"}, c, 1);
        check({e.tag, "_wr_addr"}, bus.o_mem_w_addr, e.addr);
        check({e.tag, "_wr_data"}, bus.o_mem_w_data, e.wdata);
        check({e.tag, "_wr_mode"}, bus.o_mem_w_addressing, e.sz);
      end
      if (bus.o_done === 1'b1) begin
        got = 1;
        check({e.tag, "_latency"}, c, e.lat);
        check({e.tag, "_rdata"}, bus.o_rdata, e.rdata);
        check({e.tag, "_misaligned"}, bus.o_misaligned, e.mis);
        check({e.tag, "_illegal"}, bus.o_illegal, e.ill);
      end
    end
    check({e.tag, "_done_seen"}, got, 1'b1);
    check({e.tag, "_rd_strobes"}, rd_n, e.rd);
    check({e.tag, "_wr_strobes"}, wr_n, e.wr);
    @(negedge clk);
    check({e.tag, "_ready_back"}, bus.o_ready, 1'b1);
  endtask

  task automatic issue(input string tag, input logic ld, input logic st, input logic [1:0] sz,
                       input logic u, input logic [5:0] a, input logic [31:0] wd);
    wait_ready();
    drive(ld, st, sz, u, a, wd);
    push_expected(tag, ld, st, sz, u, a, wd);
    @(posedge clk);
    #1;
    scramble();
    collect();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t ea;
    rst            = 1'b1;
    mem_init       = 1'b1;
    bus.i_valid    = 1'b0;
    bus.i_is_load  = 1'b0;
    bus.i_is_store = 1'b0;
    bus.i_size     = 2'b00;
    bus.i_unsigned = 1'b0;
    bus.i_addr     = '0;
    bus.i_wdata    = '0;
    last_rdata     = '0;
    for (int i = 0; i < 64; i++) ref_mem[i] = 8'(i);
    repeat (3) @(negedge clk);

    check("rst_ready", bus.o_ready, 1'b1);
    check("rst_done", bus.o_done, 1'b0);
    check("rst_misaligned", bus.o_misaligned, 1'b0);
    check("rst_illegal", bus.o_illegal, 1'b0);
    check("rst_r_en", bus.o_mem_r_en, 1'b0);
    check("rst_w_en", bus.o_mem_w_en, 1'b0);
    check("rst_rdata", bus.o_rdata, 32'h0);
    check("rst_r_addr", bus.o_mem_r_addr, 6'h0);
    check("rst_r_mode", bus.o_mem_r_addressing, 2'b00);
    check("rst_w_addr", bus.o_mem_w_addr, 6'h0);
    check("rst_w_data", bus.o_mem_w_data, 32'h0);
    check("rst_w_mode", bus.o_mem_w_addressing, 2'b00);
    rst      = 1'b0;
    mem_init = 1'b0;
    @(negedge clk);

    issue("sw00",   1'b0, 1'b1, 2'b11, 1'b0, 6'h00, 32'h0123ABCD);
    issue("lw00",   1'b1, 1'b0, 2'b11, 1'b0, 6'h00, 32'h0);
    issue("sh04",   1'b0, 1'b1, 2'b01, 1'b0, 6'h04, 32'h0000ABCD);
    issue("lh04",   1'b1, 1'b0, 2'b01, 1'b0, 6'h04, 32'h0);
    issue("lhu04",  1'b1, 1'b0, 2'b01, 1'b1, 6'h04, 32'h0);
    issue("sb09",   1'b0, 1'b1, 2'b00, 1'b0, 6'h09, 32'h000000CD);
    issue("lb09",   1'b1, 1'b0, 2'b00, 1'b0, 6'h09, 32'h0);
    issue("lbu09",  1'b1, 1'b0, 2'b00, 1'b1, 6'h09, 32'h0);
    issue("lw08",   1'b1, 1'b0, 2'b11, 1'b0, 6'h08, 32'h0);
    issue("lw02",   1'b1, 1'b0, 2'b11, 1'b0, 6'h02, 32'h0);
    issue("sh05",   1'b0, 1'b1, 2'b01, 1'b0, 6'h05, 32'h0000BEEF);
    issue("sz10",   1'b1, 1'b0, 2'b10, 1'b0, 6'h10, 32'h0);
    issue("ldst",   1'b1, 1'b1, 2'b11, 1'b0, 6'h03, 32'h0);
    issue("noop",   1'b0, 1'b0, 2'b11, 1'b0, 6'h0C, 32'h0);
    issue("lw08b",  1'b1, 1'b0, 2'b11, 1'b0, 6'h08, 32'h0);

    // Reset while the read is in RD_WAIT: result discarded, rdata cleared.
    wait_ready();
    drive(1'b1, 1'b0, 2'b11, 1'b0, 6'h10, 32'h0);
    @(posedge clk);
    #1;
    scramble();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("rstmid_ready", bus.o_ready, 1'b1);
    check("rstmid_done", bus.o_done, 1'b0);
    check("rstmid_rdata", bus.o_rdata, 32'h0);
    check("rstmid_r_en", bus.o_mem_r_en, 1'b0);
    check("rstmid_r_addr", bus.o_mem_r_addr, 6'h0);
    rst = 1'b0;
    last_rdata = '0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      check("rstmid_no_done", bus.o_done, 1'b0);
    end

    // Back-to-back loads: second request held on the inputs while the first is busy.
    wait_ready();
    drive(1'b1, 1'b0, 2'b11, 1'b0, 6'h00, 32'h0);
    push_expected("b2b_a", 1'b1, 1'b0, 2'b11, 1'b0, 6'h00, 32'h0);
    ea = sb.pop_front();
    @(posedge clk);
    #1;
    drive(1'b1, 1'b0, 2'b01, 1'b1, 6'h04, 32'h0);
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      check("b2b_ready", bus.o_ready, (c == 4));
      check("b2b_done", bus.o_done, (c == 3));
      if (c == 3) check("b2b_a_rdata", bus.o_rdata, ea.rdata);
    end
    push_expected("b2b_b", 1'b1, 1'b0, 2'b01, 1'b1, 6'h04, 32'h0);
    @(posedge clk);
    #1;
    scramble();
    collect();

    issue("sb3f",   1'b0, 1'b1, 2'b00, 1'b0, 6'h3F, 32'hFFFFFF80);
    issue("lb3f",   1'b1, 1'b0, 2'b00, 1'b0, 6'h3F, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
